// File: rtl/adc_link_trainer_if.sv
// Wishbone master bus between the link trainer and the receiver's register block.
interface adc_link_trainer_if;
    logic        m_cyc;
    logic        m_stb;
    logic        m_we;
    logic [3:0]  m_adr;
    logic [31:0] m_dat_o;
    logic [31:0] m_dat_i;
    logic        m_ack;

    modport master (
        output m_cyc, m_stb, m_we, m_adr, m_dat_o,
        input  m_dat_i, m_ack
    );

    modport slave (
        input  m_cyc, m_stb, m_we, m_adr, m_dat_o,
        output m_dat_i, m_ack
    );
endinterface

// File: rtl/adc_link_trainer.sv
// ADC deserialiser link trainer: resets and calibrates the receiver, then loops
// check window -> instability readout -> per-line IODELAY increments until stable.
module adc_link_trainer #(
    parameter int unsigned CHK_LEN   = 4096,
    parameter int unsigned GAP       = 16,
    parameter int unsigned SETTLE    = 32,
    parameter int unsigned THRESH    = 0,
    parameter int unsigned MAX_STEPS = 63,
    parameter int unsigned TMO       = 255
) (
    input  logic                       wb_clk,
    input  logic                       wb_rst,
    input  logic                       start,
    adc_link_trainer_if.master         bus,
    output logic                       chk_run,
    output logic                       busy,
    output logic                       done,
    output logic                       fail,
    output logic [1:0]                 err,
    output logic [5:0]                 steps,
    output logic [8:0]                 unstable
);

    typedef enum logic [3:0] {
        StIdle,
        StInitWr,
        StInitSettle,
        StChk,
        StGap,
        StRd,
        StRdNext,
        StEval,
        StIncWr,
        StIncSettle
    } state_e;

    localparam logic [1:0] ErrNone = 2'd0;
    localparam logic [1:0] ErrStep = 2'd1;
    localparam logic [1:0] ErrTmo  = 2'd2;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  init_idx_q, init_idx_d;
    logic [3:0]  rd_idx_q, rd_idx_d;
    logic [8:0]  mask_acc_q, mask_acc_d;
    logic [8:0]  unstable_q, unstable_d;
    logic [5:0]  steps_q, steps_d;
    logic [1:0]  err_q, err_d;
    logic        done_q, done_d;
    logic        fail_q, fail_d;
    logic        busy_q, busy_d;
    logic        chk_run_q, chk_run_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  adr_q, adr_d;
    logic [15:0] dat_q, dat_d;

    logic [8:0]  mask_next;
    logic        rd_bad;
    logic        unused_dat_hi;

    // Receiver control-register words for the four init steps, in order.
    function automatic logic [15:0] init_word(input logic [1:0] idx);
        case (idx)
            2'd0:    init_word = 16'h1000;
            2'd1:    init_word = 16'h0400;
            2'd2:    init_word = 16'h0800;
            default: init_word = 16'h6000;
        endcase
    endfunction

    // Only the low byte of each readout carries the instability count.
    assign unused_dat_hi = ^bus.m_dat_i[31:8];
    assign rd_bad        = bus.m_dat_i[7:0] > 8'(THRESH);

    // Fold the current read into the mask: addr 7 is frame (bit 8), addr 8..15 are lines 0..7.
    always_comb begin
        mask_next = mask_acc_q;
        if (rd_idx_q == 4'd0) begin
            mask_next[8] = rd_bad;
        end else begin
            mask_next[rd_idx_q - 4'd1] = rd_bad;
        end
    end

    // Sequencer next-state, bus launch and status update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        init_idx_d = init_idx_q;
        rd_idx_d   = rd_idx_q;
        mask_acc_d = mask_acc_q;
        unstable_d = unstable_q;
        steps_d    = steps_q;
        err_d      = err_q;
        done_d     = done_q;
        fail_d     = fail_q;
        busy_d     = busy_q;
        chk_run_d  = chk_run_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    done_d     = 1'b0;
                    fail_d     = 1'b0;
                    err_d      = ErrNone;
                    steps_d    = 6'd0;
                    unstable_d = 9'd0;
                    busy_d     = 1'b1;
                    init_idx_d = 2'd0;
                    cyc_d      = 1'b1;
                    we_d       = 1'b1;
                    adr_d      = 4'd0;
                    dat_d      = init_word(2'd0);
                    cnt_d      = 32'd0;
                    state_d    = StInitWr;
                end
            end

            StInitWr, StRd, StIncWr: begin
                if (bus.m_ack) begin
                    cyc_d = 1'b0;
                    cnt_d = 32'd0;
                    if (state_q == StInitWr) begin
                        state_d = StInitSettle;
                    end else if (state_q == StIncWr) begin
                        state_d = StIncSettle;
                    end else begin
                        mask_acc_d = mask_next;
                        if (rd_idx_q == 4'd8) begin
                            unstable_d = mask_next;
                            state_d    = StEval;
                        end else begin
                            rd_idx_d = rd_idx_q + 4'd1;
                            state_d  = StRdNext;
                        end
                    end
                end else if (cnt_q == TMO - 1) begin
                    cyc_d   = 1'b0;
                    err_d   = ErrTmo;
                    fail_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            StInitSettle, StIncSettle: begin
                if (cnt_q == SETTLE - 1) begin
                    cnt_d = 32'd0;
                    if (state_q == StIncSettle || init_idx_q == 2'd3) begin
                        chk_run_d = 1'b1;
                        state_d   = StChk;
                    end else begin
                        init_idx_d = init_idx_q + 2'd1;
                        cyc_d      = 1'b1;
                        we_d       = 1'b1;
                        adr_d      = 4'd0;
                        dat_d      = init_word(init_idx_q + 2'd1);
                        state_d    = StInitWr;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            StChk: begin
                if (cnt_q == CHK_LEN - 1) begin
                    chk_run_d = 1'b0;
                    cnt_d     = 32'd0;
                    state_d   = StGap;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            StGap: begin
                if (cnt_q == GAP - 1) begin
                    rd_idx_d   = 4'd0;
                    mask_acc_d = 9'd0;
                    cyc_d      = 1'b1;
                    we_d       = 1'b0;
                    adr_d      = 4'd7;
                    dat_d      = 16'd0;
                    cnt_d      = 32'd0;
                    state_d    = StRd;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            // One idle bus cycle between consecutive reads.
            StRdNext: begin
                cyc_d   = 1'b1;
                we_d    = 1'b0;
                adr_d   = 4'd7 + rd_idx_q;
                dat_d   = 16'd0;
                cnt_d   = 32'd0;
                state_d = StRd;
            end

            StEval: begin
                if (unstable_q == 9'd0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (steps_q == 6'(MAX_STEPS)) begin
                    err_d   = ErrStep;
                    fail_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    steps_d = steps_q + 6'd1;
                    cyc_d   = 1'b1;
                    we_d    = 1'b1;
                    adr_d   = 4'd0;
                    dat_d   = 16'h6200 | {7'd0, unstable_q};
                    cnt_d   = 32'd0;
                    state_d = StIncWr;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // State and output registers; async reset drops the bus and check window at once.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q    <= StIdle;
            cnt_q      <= 32'd0;
            init_idx_q <= 2'd0;
            rd_idx_q   <= 4'd0;
            mask_acc_q <= 9'd0;
            unstable_q <= 9'd0;
            steps_q    <= 6'd0;
            err_q      <= ErrNone;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            busy_q     <= 1'b0;
            chk_run_q  <= 1'b0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= 4'd0;
            dat_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            init_idx_q <= init_idx_d;
            rd_idx_q   <= rd_idx_d;
            mask_acc_q <= mask_acc_d;
            unstable_q <= unstable_d;
            steps_q    <= steps_d;
            err_q      <= err_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            busy_q     <= busy_d;
            chk_run_q  <= chk_run_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
        end
    end

    assign bus.m_cyc   = cyc_q;
    assign bus.m_stb   = cyc_q;
    assign bus.m_we    = we_q;
    assign bus.m_adr   = adr_q;
    assign bus.m_dat_o = {16'd0, dat_q};
    assign chk_run     = chk_run_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fail        = fail_q;
    assign err         = err_q;
    assign steps       = steps_q;
    assign unstable    = unstable_q;

endmodule

// File: tb/tb_adc_link_trainer.sv
// Directed bench for adc_link_trainer with a behavioural Wishbone receiver model.
module tb_adc_link_trainer;

    localparam int unsigned CHK_LEN = 32;
    localparam int unsigned GAP     = 4;
    localparam int unsigned SETTLE  = 4;

    logic       wb_clk = 1'b0;
    logic       wb_rst = 1'b1;
    logic       start  = 1'b0;
    logic       chk_run, busy, done, fail;
    logic [1:0] err;
    logic [5:0] steps;
    logic [8:0] unstable;

    adc_link_trainer_if bus_if ();

    adc_link_trainer #(
        .CHK_LEN   (CHK_LEN),
        .GAP       (GAP),
        .SETTLE    (SETTLE),
        .THRESH    (0),
        .MAX_STEPS (63),
        .TMO       (255)
    ) dut (
        .wb_clk   (wb_clk),
        .wb_rst   (wb_rst),
        .start    (start),
        .bus      (bus_if),
        .chk_run  (chk_run),
        .busy     (busy),
        .done     (done),
        .fail     (fail),
        .err      (err),
        .steps    (steps),
        .unstable (unstable)
    );

    always #5 wb_clk = ~wb_clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Receiver model knobs and logs.
    int          ack_delay  = 0;
    bit          noack_0400 = 1'b0;
    logic [7:0]  frame_val  = 8'd0;
    int          line3_bad_windows = 0;
    logic [31:0] wr_q[$];
    logic [3:0]  rd_adr_q[$];
    int          win_cnt, run_len, run_min, run_max, chk_len_last, stab_viol;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wr_at(input int i);
        return (i < wr_q.size()) ? wr_q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic clear_logs();
        wr_q.delete();
        rd_adr_q.delete();
        win_cnt      = 0;
        run_min      = 1 << 30;
        run_max      = 0;
        chk_len_last = 0;
        stab_viol    = 0;
    endtask

    task automatic pulse_start();
        @(negedge wb_clk) start = 1'b1;
        @(negedge wb_clk) start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            @(negedge wb_clk);
        end
        check_val(tag, {31'd0, busy}, 32'd0);
    endtask

    // Receiver responder: acks after ack_delay waiting cycles, logs each completed access.
    initial begin : responder
        int wcnt;
        wcnt = 0;
        bus_if.m_ack   = 1'b0;
        bus_if.m_dat_i = 32'd0;
        forever begin
            @(negedge wb_clk);
            if (wb_rst || bus_if.m_ack) begin
                bus_if.m_ack = 1'b0;
                wcnt = 0;
            end else if (bus_if.m_cyc && bus_if.m_stb) begin
                if (noack_0400 && bus_if.m_we && bus_if.m_dat_o == 32'h0400) begin
                    wcnt = 0;
                end else if (wcnt >= ack_delay) begin
                    bus_if.m_ack = 1'b1;
                    if (bus_if.m_we) begin
                        wr_q.push_back(bus_if.m_dat_o);
                        bus_if.m_dat_i = 32'd0;
                    end else begin
                        rd_adr_q.push_back(bus_if.m_adr);
                        if (bus_if.m_adr == 4'd7)
                            bus_if.m_dat_i = {24'hABCDEF, frame_val};
                        else if (bus_if.m_adr == 4'd11 && win_cnt <= line3_bad_windows)
                            bus_if.m_dat_i = 32'h0000_0005;
                        else
                            bus_if.m_dat_i = 32'hFFFF_FF00;
                    end
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Monitor: chk_run pulse length/count, cyc run lengths, request stability while cyc held.
    initial begin : monitor
        int       chk_cur;
        logic     cyc_prev, chk_prev;
        logic [36:0] req_prev;
        chk_cur  = 0;
        run_len  = 0;
        cyc_prev = 1'b0;
        chk_prev = 1'b0;
        req_prev = '0;
        forever begin
            @(negedge wb_clk);
            if (chk_run) begin
                if (!chk_prev) win_cnt++;
                chk_cur++;
            end else if (chk_prev) begin
                chk_len_last = chk_cur;
                chk_cur = 0;
            end
            chk_prev = chk_run;
            if (bus_if.m_cyc) begin
                run_len++;
                if (cyc_prev && req_prev !== {bus_if.m_we, bus_if.m_adr, bus_if.m_dat_o})
                    stab_viol++;
            end else if (run_len > 0) begin
                if (run_len < run_min) run_min = run_len;
                if (run_len > run_max) run_max = run_len;
                run_len = 0;
            end
            cyc_prev = bus_if.m_cyc;
            req_prev = {bus_if.m_we, bus_if.m_adr, bus_if.m_dat_o};
        end
    end

    initial begin : stim
        int n_inc;
        clear_logs();
        repeat (3) @(negedge wb_clk);
        wb_rst = 1'b0;
        @(negedge wb_clk);

        // Reset state.
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_flags", {28'd0, done, fail, err}, 32'd0);
        check_val("rst_steps_unstable", {17'd0, steps, unstable}, 32'd0);
        check_val("rst_bus", {26'd0, bus_if.m_cyc, bus_if.m_stb, bus_if.m_we, chk_run, 2'd0},
                  32'd0);
        check_val("rst_adr", {28'd0, bus_if.m_adr}, 32'd0);
        check_val("rst_dat", bus_if.m_dat_o, 32'd0);

        // Stable link.
        clear_logs();
        pulse_start();
        check_val("t1_busy_rise", {31'd0, busy}, 32'd1);
        wait_idle("t1_timeout", 2000);
        check_val("t1_nwr", wr_q.size(), 32'd4);
        check_val("t1_wr0", wr_at(0), 32'h1000);
        check_val("t1_wr1", wr_at(1), 32'h0400);
        check_val("t1_wr2", wr_at(2), 32'h0800);
        check_val("t1_wr3", wr_at(3), 32'h6000);
        check_val("t1_windows", win_cnt, 32'd1);
        check_val("t1_chk_len", chk_len_last, CHK_LEN);
        check_val("t1_nrd", rd_adr_q.size(), 32'd9);
        for (int i = 0; i < 9; i++)
            check_val($sformatf("t1_rd_adr%0d", i),
                      (i < rd_adr_q.size()) ? {28'd0, rd_adr_q[i]} : 32'hFFFF, 7 + i);
        check_val("t1_status", {21'd0, done, fail, err, steps},
                  {21'd0, 1'b1, 1'b0, 2'd0, 6'd0});
        check_val("t1_unstable", {23'd0, unstable}, 32'd0);
        check_val("t1_stab", stab_viol, 32'd0);

        // Line 3 unstable for two windows.
        clear_logs();
        line3_bad_windows = 2;
        pulse_start();
        wait_idle("t2_timeout", 4000);
        check_val("t2_nwr", wr_q.size(), 32'd6);
        check_val("t2_inc0", wr_at(4), 32'h6208);
        check_val("t2_inc1", wr_at(5), 32'h6208);
        check_val("t2_windows", win_cnt, 32'd3);
        check_val("t2_status", {21'd0, done, fail, err, steps},
                  {21'd0, 1'b1, 1'b0, 2'd0, 6'd2});
        check_val("t2_unstable", {23'd0, unstable}, 32'd0);
        line3_bad_windows = 0;

        // Frame never stable: step limit.
        clear_logs();
        frame_val = 8'hFF;
        pulse_start();
        wait_idle("t3_timeout", 30000);
        n_inc = 0;
        foreach (wr_q[i]) if (wr_q[i] == 32'h6300) n_inc++;
        check_val("t3_ninc", n_inc, 32'd63);
        check_val("t3_nwr", wr_q.size(), 32'd67);
        check_val("t3_status", {21'd0, done, fail, err, steps},
                  {21'd0, 1'b0, 1'b1, 2'd1, 6'd63});
        check_val("t3_unstable", {23'd0, unstable}, 32'h100);
        frame_val = 8'd0;

        // No ack on the second init write: bus timeout.
        clear_logs();
        noack_0400 = 1'b1;
        pulse_start();
        wait_idle("t4_timeout", 2000);
        check_val("t4_cyc_len", run_max, 32'd255);
        check_val("t4_cyc_low", {31'd0, bus_if.m_cyc}, 32'd0);
        check_val("t4_nwr", wr_q.size(), 32'd1);
        check_val("t4_status", {28'd0, done, fail, err}, {28'd0, 1'b0, 1'b1, 2'd2});
        noack_0400 = 1'b0;

        // Async reset during the check window.
        clear_logs();
        pulse_start();
        for (int i = 0; i < 500; i++) begin
            if (chk_run) break;
            @(negedge wb_clk);
        end
        check_val("t5_chk_seen", {31'd0, chk_run}, 32'd1);
        repeat (5) @(negedge wb_clk);
        #2 wb_rst = 1'b1;
        #1;
        check_val("t5_async", {29'd0, chk_run, busy, bus_if.m_cyc}, 32'd0);
        @(negedge wb_clk) wb_rst = 1'b0;
        check_val("t5_flags", {29'd0, done, fail, |err}, 32'd0);
        clear_logs();
        pulse_start();
        wait_idle("t5_timeout", 2000);
        check_val("t5_wr0", wr_at(0), 32'h1000);
        check_val("t5_nwr", wr_q.size(), 32'd4);
        check_val("t5_done", {31'd0, done}, 32'd1);

        // Slow acks plus extra start pulses while busy.
        clear_logs();
        ack_delay = 3;
        pulse_start();
        repeat (10) @(negedge wb_clk);
        pulse_start();
        repeat (60) @(negedge wb_clk);
        pulse_start();
        wait_idle("t6_timeout", 4000);
        check_val("t6_nwr", wr_q.size(), 32'd4);
        check_val("t6_wr3", wr_at(3), 32'h6000);
        check_val("t6_nrd", rd_adr_q.size(), 32'd9);
        check_val("t6_windows", win_cnt, 32'd1);
        check_val("t6_run_min", run_min, 32'd4);
        check_val("t6_run_max", run_max, 32'd4);
        check_val("t6_stab", stab_viol, 32'd0);
        check_val("t6_done", {31'd0, done}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
